// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage controllers.
// Holds the stage state encoding and the twiddle index helper.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAD,
    DRAIN
  } state_t;

  // Twiddle index = count * stride; the caller truncates to its width.
  function automatic int unsigned tm_index(
    input int unsigned cnt,
    input int unsigned stride
  );
    return cnt * stride;
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Enable-gated shift register carrying {produce, sop} tags
// alongside the PE pipeline so framing lines up with dout.
module tag_delay #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_tag,
  output logic [1:0] o_tag
);

  logic [1:0] r_sr [DEPTH];

  // Shift tags only when the PE advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_tag = r_sr[DEPTH-1];

endmodule

// File: rtl/sdf_pe_ctrl.sv
// Control sequencer for one SDF radix-2 DIF stage: PE advance,
// mux/twiddle decode, output framing and FIFO flush sequencing.
module sdf_pe_ctrl
  import fft_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TM_WIDTH       = 2,
  parameter int TWIDDLE_STRIDE = 1,
  parameter int PE_LATENCY     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                flush,
  output logic                halt_ctrl,
  output logic                mux_ctrl,
  output logic [TM_WIDTH-1:0] tm_ctrl,
  output logic                zero_din,
  output logic                out_valid,
  output logic                out_sop,
  output logic                busy
);

  localparam int CW = $clog2(2 * FIFO_DEPTH);
  localparam int DW = $clog2(FIFO_DEPTH + PE_LATENCY);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [DW-1:0] r_dcnt;
  logic          r_primed;
  logic          w_busy;
  logic          w_adv;
  logic          w_drain_end;
  logic          w_produce;
  logic          w_sop;
  logic [1:0]    w_tag_q;

  // Advance decode; reset forces the PE to hold immediately.
  always_comb begin
    w_busy      = (r_state == PAD) || (r_state == DRAIN);
    w_adv       = ~rst & (w_busy | in_valid);
    w_cnt_inc   = r_cnt + CW'(1);
    w_drain_end = (r_state == DRAIN) &&
                  (r_dcnt == DW'(FIFO_DEPTH + PE_LATENCY - 1));
    w_produce   = r_primed &
                  ~((r_state == DRAIN) &&
                    (r_dcnt >= DW'(FIFO_DEPTH)));
    w_sop       = w_produce & (r_cnt == CW'(FIFO_DEPTH));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: flush decides PAD vs DRAIN on the post-advance count.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_adv) w_next = RUN;
      end
      RUN: begin
        if (flush) begin
          if ((w_adv ? w_cnt_inc : r_cnt) == '0) w_next = DRAIN;
          else                                  w_next = PAD;
        end
      end
      PAD: begin
        if (w_cnt_inc == '0) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_drain_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Sample counter, priming flag and drain length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_primed <= 1'b0;
    end else if (w_drain_end) begin
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_primed <= 1'b0;
    end else if (w_adv) begin
      r_cnt <= w_cnt_inc;
      if (r_cnt == CW'(FIFO_DEPTH - 1)) r_primed <= 1'b1;
      if (r_state == DRAIN) r_dcnt <= r_dcnt + DW'(1);
    end
  end

  tag_delay #(
    .DEPTH (PE_LATENCY)
  ) u_tag (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_adv),
    .i_tag ({w_produce, w_sop}),
    .o_tag (w_tag_q)
  );

  // Output decode from registered state and the tag tail.
  always_comb begin
    halt_ctrl = w_adv;
    mux_ctrl  = r_cnt[CW-1];
    tm_ctrl   = '0;
    if (!r_cnt[CW-1] && r_primed)
      tm_ctrl = TM_WIDTH'(tm_index(int'(r_cnt[CW-2:0]),
                                   $unsigned(TWIDDLE_STRIDE)));
    zero_din  = w_busy;
    busy      = w_busy;
    out_valid = w_tag_q[1] & w_adv;
    out_sop   = w_tag_q[0] & w_adv;
  end

endmodule
